hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
Hazard and stall controller that drives the enable and flush inputs of the fetch/decode buffer and the decode/execute-memory buffer, and the PC register enable.
- Consumes decode-stage operand info and the control fields leaving the decode/execute-memory buffer (mem_read, write_back, rd, push_pc, pop_pc), plus branch resolution.
- Sequences load-use bubbles, multi-word PC push/pop stalls and branch flushes.
- Sits beside the pipeline registers; it is the producer of their stall/flush controls.

Parameters:
PC_WORDS, 2, number of 16-bit memory words per PC push/pop (≥1)
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (≥1)

Ports:
i_clk  input  1  clock, rising edge
i_reset  input  1  asynchronous, active-high reset
i_dec_rs  input  3  decode-stage source register 1
i_dec_rt  input  3  decode-stage source register 2
i_dec_uses_rs  input  1  decode instruction reads rs
i_dec_uses_rt  input  1  decode instruction reads rt
i_ex_mem_read  input  1  execute-memory instruction is a load
i_ex_write_back  input  1  execute-memory instruction writes a register
i_ex_rd  input  3  execute-memory destination register
i_ex_push_pc  input  1  execute-memory instruction pushes PC (CALL/INT)
i_ex_pop_pc  input  1  execute-memory instruction pops PC (RET/RTI)
i_branch_taken  input  1  branch resolved taken this cycle
o_pc_enable  output  1  PC register may update
o_fd_enable  output  1  fetch/decode buffer load enable
o_fd_flush  output  1  fetch/decode buffer loads NOP at next edge
o_de_enable  output  1  decode/execute-memory buffer load enable
o_de_flush  output  1  decode/execute-memory buffer loads all-zero bubble at next edge
o_pc_word_sel  output  CW  current PC word index for stack memory; CW = max(1, $clog2(PC_WORDS))
o_busy  output  1  controller not in S_IDLE

Behaviour:
- States: S_IDLE, S_LOAD (remaining load bubbles), S_PCOP (multi-word PC transfer).
- Registered: state, down-counter cnt (width ≥ CW and ≥ $clog2(LOAD_STALL_CYCLES)), pop flag.
- Outputs are combinational from state and inputs (Mealy).
- Reset (async, any time, including mid-S_PCOP): state = S_IDLE, cnt = 0, pop flag = 0.
  - Outputs then evaluate to the S_IDLE no-hazard values: pc/fd/de enable = 1, both flushes = 0, o_pc_word_sel = 0, o_busy = 0.
- Hazard terms:
  - load_use = i_ex_mem_read & i_ex_write_back & ((i_dec_uses_rs & i_dec_rs==i_ex_rd) | (i_dec_uses_rt & i_dec_rt==i_ex_rd)).
  - pcop = i_ex_push_pc | i_ex_pop_pc.
- S_IDLE priority: pcop > i_branch_taken > load_use > normal.
  - pcop with PC_WORDS>1:
    - That cycle: pc/fd/de enable = 0, o_pc_word_sel = 0.
    - Next state S_PCOP, cnt = PC_WORDS-1, pop flag = i_ex_pop_pc.
  - pcop with PC_WORDS=1: treated as a completed PC op (see S_PCOP exit).
  - Branch: o_fd_flush = 1, o_de_flush = 1, pc_enable = 1; stay in S_IDLE.
  - load_use:
    - That cycle: pc_enable = 0, fd_enable = 0, de_flush = 1.
    - If LOAD_STALL_CYCLES>1: next state S_LOAD, cnt = LOAD_STALL_CYCLES-1.
  - Normal: all enables 1, flushes 0.
- S_LOAD:
  - pc/fd enable = 0, de_flush = 1.
  - cnt decrements; at cnt==1, return to S_IDLE.
  - Branch input ignored, because the bubble sits ahead of the branch.
- S_PCOP:
  - pc/fd/de enable = 0, o_pc_word_sel = PC_WORDS-cnt.
  - cnt decrements; at cnt==1 this is the exit cycle:
    - Return to S_IDLE.
    - If pop flag: o_fd_flush = 1, o_de_flush = 1, pc_enable = 1 (PC loads popped value); otherwise all enables = 1.
- Flush dominates enable: the buffer loads the bubble even when enable = 0.
- A stalled pcop instruction held in the execute-memory buffer does not retrigger S_PCOP on exit, because the exit cycle loads the next instruction.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds output o_stall_cycles [15:0].
  - Counts cycles with o_pc_enable == 0.
  - Saturates at 16'hFFFF; async reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package: state encoding (S_IDLE=2'd0, S_LOAD=2'd1, S_PCOP=2'd2), register-index width constant (3), data word width (16).
- Sub-module hazard_detect: purely combinational load_use/pcop comparison, instantiated once.

Test Plan:
- Load r3 in EX, decode ADD reading rs=3 → one cycle: pc_enable=0, fd_enable=0, de_flush=1; next cycle all enables 1.
- Load r3 in EX, decode uses rt=4 only → no stall; enables 1, flushes 0.
- i_ex_pop_pc=1, PC_WORDS=2:
  - Cycle 0: all enables 0, word_sel=0, o_busy 0→1.
  - Cycle 1: word_sel=1, fd_flush=1, de_flush=1, pc_enable=1.
  - Cycle 2: idle.
- i_ex_push_pc=1 and i_branch_taken=1 together → push sequence wins; no flush on exit.
- i_branch_taken=1 with load_use=1 in S_IDLE → both flushes 1, pc_enable=1, no S_LOAD entry.
- Assert i_reset during S_PCOP cycle 1 → immediately o_busy=0, enables 1, word_sel 0; (HAZARD_PERF_CNT_EN) o_stall_cycles=0.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the hazard/stall controller and its detector.
package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PCOP = 2'd2
  } state_e;

  localparam int REG_W  = 3;
  localparam int WORD_W = 16;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// Combinational load-use and PC push/pop detection; zero latency, no flow control.
module hazard_detect
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] i_dec_rs,
  input  logic [REG_W-1:0] i_dec_rt,
  input  logic             i_dec_uses_rs,
  input  logic             i_dec_uses_rt,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_write_back,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_push_pc,
  input  logic             i_ex_pop_pc,
  output logic             o_load_use,
  output logic             o_pcop
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit     = i_dec_uses_rs && (i_dec_rs == i_ex_rd);
  assign rt_hit     = i_dec_uses_rt && (i_dec_rt == i_ex_rd);
  assign o_load_use = i_ex_mem_read && i_ex_write_back && (rs_hit || rt_hit);
  assign o_pcop     = i_ex_push_pc || i_ex_pop_pc;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush sequencer (Mealy outputs, same-cycle); inserts load bubbles and multi-word PC stalls.
// Optional HAZARD_PERF_CNT_EN adds a saturating count of PC-stalled cycles.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int PC_WORDS          = 2,
  parameter int LOAD_STALL_CYCLES = 1,
  localparam int CW               = max2(1, $clog2(PC_WORDS))
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [REG_W-1:0] i_dec_rs,
  input  logic [REG_W-1:0] i_dec_rt,
  input  logic             i_dec_uses_rs,
  input  logic             i_dec_uses_rt,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_write_back,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_push_pc,
  input  logic             i_ex_pop_pc,
  input  logic             i_branch_taken,
  output logic             o_pc_enable,
  output logic             o_fd_enable,
  output logic             o_fd_flush,
  output logic             o_de_enable,
  output logic             o_de_flush,
  output logic [CW-1:0]    o_pc_word_sel,
  output logic             o_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]      o_stall_cycles
`endif
);

  localparam int CNT_W = max2(CW, max2(1, $clog2(LOAD_STALL_CYCLES)));
  localparam logic [CNT_W-1:0] PC_LAST   = CNT_W'(PC_WORDS - 1);
  localparam logic [CNT_W-1:0] LOAD_INIT = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop_q, pop_d;
  logic             load_use;
  logic             pcop;

  hazard_detect u_detect (
    .i_dec_rs        (i_dec_rs),
    .i_dec_rt        (i_dec_rt),
    .i_dec_uses_rs   (i_dec_uses_rs),
    .i_dec_uses_rt   (i_dec_uses_rt),
    .i_ex_mem_read   (i_ex_mem_read),
    .i_ex_write_back (i_ex_write_back),
    .i_ex_rd         (i_ex_rd),
    .i_ex_push_pc    (i_ex_push_pc),
    .i_ex_pop_pc     (i_ex_pop_pc),
    .o_load_use      (load_use),
    .o_pcop          (pcop)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pop_q   <= pop_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pop_d         = pop_q;
    o_pc_enable   = 1'b1;
    o_fd_enable   = 1'b1;
    o_de_enable   = 1'b1;
    o_fd_flush    = 1'b0;
    o_de_flush    = 1'b0;
    o_pc_word_sel = '0;
    unique case (state_q)
      S_IDLE: begin
        if (pcop) begin
          if (PC_WORDS > 1) begin
            o_pc_enable = 1'b0;
            o_fd_enable = 1'b0;
            o_de_enable = 1'b0;
            state_d     = S_PCOP;
            cnt_d       = PC_LAST;
            pop_d       = i_ex_pop_pc;
          end else if (i_ex_pop_pc) begin
            o_fd_flush = 1'b1;
            o_de_flush = 1'b1;
          end
        end else if (i_branch_taken) begin
          o_fd_flush = 1'b1;
          o_de_flush = 1'b1;
        end else if (load_use) begin
          o_pc_enable = 1'b0;
          o_fd_enable = 1'b0;
          o_de_flush  = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = S_LOAD;
            cnt_d   = LOAD_INIT;
          end
        end
      end
      // The bubble is older than any branch in decode, so branches are ignored here.
      S_LOAD: begin
        o_pc_enable = 1'b0;
        o_fd_enable = 1'b0;
        o_de_flush  = 1'b1;
        cnt_d       = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_IDLE;
        end
      end
      S_PCOP: begin
        o_pc_word_sel = CW'(PC_WORDS) - CW'(cnt_q);
        cnt_d         = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_IDLE;
          pop_d   = 1'b0;
          if (pop_q) begin
            o_fd_flush = 1'b1;
            o_de_flush = 1'b1;
          end
        end else begin
          o_pc_enable = 1'b0;
          o_fd_enable = 1'b0;
          o_de_enable = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_busy = (state_q != S_IDLE);

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stall_q <= '0;
    end else if (!o_pc_enable && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign o_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two configurations driven in parallel, per-cycle model compare plus literal checks.
module tb_hazard_stall_ctrl;

  localparam int PWA = 2, LSA = 1;
  localparam int PWB = 4, LSB = 3;

  typedef struct packed {
    logic       pc, fd, de, fdf, def, busy;
    logic [7:0] sel;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dec_rs = '0, dec_rt = '0, ex_rd = '0;
  logic       uses_rs = 0, uses_rt = 0, mem_rd = 0, wb = 0, push = 0, pop = 0, br = 0;

  logic       a_pc, a_fd, a_fdf, a_de, a_def, a_busy;
  logic [0:0] a_sel;
  logic       b_pc, b_fd, b_fdf, b_de, b_def, b_busy;
  logic [1:0] b_sel;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] a_stc, b_stc;
`endif

  int n_pass = 0;
  int n_total = 0;

  int a_ph = 0, a_ld = 0, b_ph = 0, b_ld = 0;
  bit a_pp = 0, b_pp = 0;
  int a_st = 0, b_st = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.PC_WORDS(PWA), .LOAD_STALL_CYCLES(LSA)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_dec_rs(dec_rs), .i_dec_rt(dec_rt),
    .i_dec_uses_rs(uses_rs), .i_dec_uses_rt(uses_rt), .i_ex_mem_read(mem_rd),
    .i_ex_write_back(wb), .i_ex_rd(ex_rd), .i_ex_push_pc(push), .i_ex_pop_pc(pop),
    .i_branch_taken(br), .o_pc_enable(a_pc), .o_fd_enable(a_fd), .o_fd_flush(a_fdf),
    .o_de_enable(a_de), .o_de_flush(a_def), .o_pc_word_sel(a_sel), .o_busy(a_busy)
`ifdef HAZARD_PERF_CNT_EN
    , .o_stall_cycles(a_stc)
`endif
  );

  hazard_stall_ctrl #(.PC_WORDS(PWB), .LOAD_STALL_CYCLES(LSB)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_dec_rs(dec_rs), .i_dec_rt(dec_rt),
    .i_dec_uses_rs(uses_rs), .i_dec_uses_rt(uses_rt), .i_ex_mem_read(mem_rd),
    .i_ex_write_back(wb), .i_ex_rd(ex_rd), .i_ex_push_pc(push), .i_ex_pop_pc(pop),
    .i_branch_taken(br), .o_pc_enable(b_pc), .o_fd_enable(b_fd), .o_fd_flush(b_fdf),
    .o_de_enable(b_de), .o_de_flush(b_def), .o_pc_word_sel(b_sel), .o_busy(b_busy)
`ifdef HAZARD_PERF_CNT_EN
    , .o_stall_cycles(b_stc)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Model state: ph = PC words already transferred (0 = none), ld = bubbles still owed.
  function automatic exp_t model_out(input int pw, input int ph, input int ld, input bit pp);
    exp_t e;
    bit lu;
    lu = mem_rd && wb && ((uses_rs && dec_rs == ex_rd) || (uses_rt && dec_rt == ex_rd));
    e.pc = 1; e.fd = 1; e.de = 1; e.fdf = 0; e.def = 0; e.sel = 0;
    e.busy = (ph > 0) || (ld > 0);
    if (ph > 0) begin
      e.sel = 8'(ph);
      if (ph == pw - 1) begin
        if (pp) begin e.fdf = 1; e.def = 1; end
      end else begin
        e.pc = 0; e.fd = 0; e.de = 0;
      end
    end else if (ld > 0) begin
      e.pc = 0; e.fd = 0; e.def = 1;
    end else if (push || pop) begin
      if (pw > 1) begin
        e.pc = 0; e.fd = 0; e.de = 0;
      end else if (pop) begin
        e.fdf = 1; e.def = 1;
      end
    end else if (br) begin
      e.fdf = 1; e.def = 1;
    end else if (lu) begin
      e.pc = 0; e.fd = 0; e.def = 1;
    end
    return e;
  endfunction

  task automatic step(input int pw, input int lsc, input int ph, input int ld, input bit pp,
                      output int nph, output int nld, output bit npp);
    bit lu;
    lu = mem_rd && wb && ((uses_rs && dec_rs == ex_rd) || (uses_rt && dec_rt == ex_rd));
    nph = ph; nld = ld; npp = pp;
    if (ph > 0) nph = (ph == pw - 1) ? 0 : ph + 1;
    else if (ld > 0) nld = ld - 1;
    else if (push || pop) begin
      if (pw > 1) begin nph = 1; npp = pop; end
    end else if (!br && lu) nld = lsc - 1;
  endtask

  always @(posedge clk or posedge rst) begin
    int nph, nld;
    bit npp;
    if (rst) begin
      a_ph <= 0; a_ld <= 0; a_pp <= 0; a_st <= 0;
      b_ph <= 0; b_ld <= 0; b_pp <= 0; b_st <= 0;
    end else begin
      if (!model_out(PWA, a_ph, a_ld, a_pp).pc && a_st < 65535) a_st <= a_st + 1;
      if (!model_out(PWB, b_ph, b_ld, b_pp).pc && b_st < 65535) b_st <= b_st + 1;
      step(PWA, LSA, a_ph, a_ld, a_pp, nph, nld, npp);
      a_ph <= nph; a_ld <= nld; a_pp <= npp;
      step(PWB, LSB, b_ph, b_ld, b_pp, nph, nld, npp);
      b_ph <= nph; b_ld <= nld; b_pp <= npp;
    end
  end

  task automatic cmp(input string t, input exp_t e, input logic pc, input logic fd, input logic de,
                     input logic fdf, input logic def, input logic busy, input logic [7:0] sel);
    chk({t, " pc_enable"}, int'(pc), int'(e.pc));
    if (!e.fdf) chk({t, " fd_enable"}, int'(fd), int'(e.fd));
    if (!e.def) chk({t, " de_enable"}, int'(de), int'(e.de));
    chk({t, " fd_flush"}, int'(fdf), int'(e.fdf));
    chk({t, " de_flush"}, int'(def), int'(e.def));
    chk({t, " busy"}, int'(busy), int'(e.busy));
    chk({t, " word_sel"}, int'(sel), int'(e.sel));
  endtask

  always @(negedge clk) begin
    cmp("A", model_out(PWA, a_ph, a_ld, a_pp), a_pc, a_fd, a_de, a_fdf, a_def, a_busy, 8'(a_sel));
    cmp("B", model_out(PWB, b_ph, b_ld, b_pp), b_pc, b_fd, b_de, b_fdf, b_def, b_busy, 8'(b_sel));
`ifdef HAZARD_PERF_CNT_EN
    chk("A stall_cycles", int'(a_stc), a_st);
    chk("B stall_cycles", int'(b_stc), b_st);
`endif
  end

  task automatic drive(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                       input bit urs, input bit urt, input bit mr, input bit w,
                       input bit pu, input bit po, input bit b);
    @(posedge clk);
    #1;
    dec_rs = rs; dec_rt = rt; ex_rd = rd; uses_rs = urs; uses_rt = urt;
    mem_rd = mr; wb = w; push = pu; pop = po; br = b;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset pc_enable", int'(a_pc), 1);
    chk("reset busy", int'(a_busy), 0);
    chk("reset word_sel", int'(a_sel), 0);
    chk("reset de_flush", int'(a_def), 0);

    // Load r3 in EX, decode reads rs=3
    drive(3, 4, 3, 1, 0, 1, 1, 0, 0, 0);
    chk("lu A pc_enable", int'(a_pc), 0);
    chk("lu A fd_enable", int'(a_fd), 0);
    chk("lu A de_flush", int'(a_def), 1);
    chk("lu B pc_enable", int'(b_pc), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("lu+1 A pc_enable", int'(a_pc), 1);
    chk("lu+1 A fd_flush br", int'(a_fdf), 1);
    chk("lu+1 B busy", int'(b_busy), 1);
    chk("lu+1 B fd_flush ignored", int'(b_fdf), 0);
    chk("lu+1 B pc_enable", int'(b_pc), 0);
    idle(3);
    chk("lu end B busy", int'(b_busy), 0);

    // Load r3, decode uses only rt=4
    drive(3, 4, 3, 0, 1, 1, 1, 0, 0, 0);
    chk("nolu A pc_enable", int'(a_pc), 1);
    chk("nolu A fd_enable", int'(a_fd), 1);
    chk("nolu A de_flush", int'(a_def), 0);

    // Pop PC, two words
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("pop c0 pc_enable", int'(a_pc), 0);
    chk("pop c0 de_enable", int'(a_de), 0);
    chk("pop c0 busy", int'(a_busy), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("pop c1 word_sel", int'(a_sel), 1);
    chk("pop c1 fd_flush", int'(a_fdf), 1);
    chk("pop c1 de_flush", int'(a_def), 1);
    chk("pop c1 pc_enable", int'(a_pc), 1);
    chk("pop c1 B word_sel", int'(b_sel), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pop c2 busy", int'(a_busy), 0);
    chk("pop c2 B word_sel", int'(b_sel), 2);
    idle(3);

    // Push with simultaneous branch
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    chk("push c0 pc_enable", int'(a_pc), 0);
    chk("push c0 fd_flush", int'(a_fdf), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("push c1 fd_flush", int'(a_fdf), 0);
    chk("push c1 fd_enable", int'(a_fd), 1);
    chk("push c1 de_enable", int'(a_de), 1);
    idle(4);

    // Branch together with load-use
    drive(3, 0, 3, 1, 0, 1, 1, 0, 0, 1);
    chk("brlu fd_flush", int'(a_fdf), 1);
    chk("brlu de_flush", int'(a_def), 1);
    chk("brlu pc_enable", int'(a_pc), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("brlu+1 B busy", int'(b_busy), 0);

    // Reset during second word of a pop
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    rst = 1'b1; pop = 0;
    #1;
    chk("rst busy", int'(a_busy), 0);
    chk("rst pc_enable", int'(a_pc), 1);
    chk("rst fd_enable", int'(a_fd), 1);
    chk("rst de_enable", int'(a_de), 1);
    chk("rst word_sel", int'(a_sel), 0);
    chk("rst B busy", int'(b_busy), 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("rst stall_cycles", int'(a_stc), 0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
